// File: rtl/norm_shift_ctrl_pkg.sv
// Shared definitions for the FPU add/subtract normalisation controller:
// default datapath widths, shift-direction encoding and the result-class enum.
package norm_shift_ctrl_pkg;

  localparam int SWR_DEF = 26;  // significand width incl. carry-out and hidden bit
  localparam int EW_DEF  = 5;   // shift-amount width
  localparam int EWE_DEF = 8;   // exponent width

  // Barrel-shifter direction encoding
  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } shift_dir_e;

  localparam shift_dir_e SHIFT_LEFT  = DIR_LEFT;
  localparam shift_dir_e SHIFT_RIGHT = DIR_RIGHT;

  // Classification of one S1 beat; selects which rule builds the S2 outputs
  typedef enum logic [1:0] {
    CASE_ZERO  = 2'd0,  // significand is all zeros
    CASE_CARRY = 2'd1,  // carry-out set, one-bit right shift
    CASE_NORM  = 2'd2,  // left shift, exponent stays above zero
    CASE_UNF   = 2'd3   // left shift clamped, denormal result
  } norm_case_e;

  // Largest shift amount representable on an ew-bit shift bus
  function automatic int max_shift(input int ew);
    return (2 ** ew) - 1;
  endfunction

endpackage

// File: rtl/norm_shift_ctrl_if.sv
// Handshake/data bundle between the significand adder, the normalisation
// controller and the barrel shifter. sticky_o exists only when NORM_STICKY_EN
// is defined.
interface norm_shift_ctrl_if
  import norm_shift_ctrl_pkg::*;
#(
  parameter int SWR = SWR_DEF,
  parameter int EW  = EW_DEF,
  parameter int EWE = EWE_DEF
);

  // Upstream side (from the adder)
  logic           valid_i;
  logic           ready_o;
  logic [SWR-1:0] Data_i;
  logic [EWE-1:0] Exp_i;

  // Downstream side (to the barrel shifter)
  logic           valid_o;
  logic           ready_i;
  logic [SWR-1:0] Data_o;
  logic           FSM_left_right_o;
  logic [EW-1:0]  Shift_Value_o;
  logic           bit_shift_o;
  logic [EWE-1:0] Exp_o;
  logic           zero_o;
  logic           ovf_o;
  logic           unf_o;
`ifdef NORM_STICKY_EN
  logic           sticky_o;
`endif

  // Controller view
  modport slave (
`ifdef NORM_STICKY_EN
    output sticky_o,
`endif
    input  valid_i, Data_i, Exp_i, ready_i,
    output ready_o, valid_o, Data_o, FSM_left_right_o, Shift_Value_o,
    output bit_shift_o, Exp_o, zero_o, ovf_o, unf_o
  );

  // Environment view (adder + shifter)
  modport master (
`ifdef NORM_STICKY_EN
    input  sticky_o,
`endif
    output valid_i, Data_i, Exp_i, ready_i,
    input  ready_o, valid_o, Data_o, FSM_left_right_o, Shift_Value_o,
    input  bit_shift_o, Exp_o, zero_o, ovf_o, unf_o
  );

endinterface

// File: rtl/norm_shift_ctrl_lzd.sv
// lzd_priority_enc: combinational leading-one detector. Returns the bit index
// of the most significant set bit of data_i and an all-zero flag. When data_i
// is zero, pos_o is 0 and zero_o is 1.
module lzd_priority_enc #(
  parameter int SWR = 26,
  parameter int EW  = 5
) (
  input  logic [SWR-1:0] data_i,
  output logic [EW-1:0]  pos_o,
  output logic           zero_o
);

  // Scan upward so the highest set bit is the last one to win
  always_comb begin
    pos_o  = {EW{1'b0}};
    zero_o = 1'b1;
    for (int i = 0; i < SWR; i++) begin
      pos_o  = data_i[i] ? EW'(i) : pos_o;
      zero_o = data_i[i] ? 1'b0   : zero_o;
    end
  end

endmodule

// File: rtl/norm_shift_ctrl.sv
// norm_shift_ctrl: two-stage normalisation controller for the FPU add/sub path.
//   S1 registers Data_i/Exp_i plus the leading-one position and zero flag.
//   S2 registers shift direction/amount, adjusted exponent and the flags.
// Latency is 2 cycles, throughput 1 beat/cycle, and stalls hold all outputs.
// Optional feature macro: NORM_STICKY_EN (adds sticky_o = bit lost on right shift).
module norm_shift_ctrl
  import norm_shift_ctrl_pkg::*;
#(
  parameter int SWR = SWR_DEF,
  parameter int EW  = EW_DEF,
  parameter int EWE = EWE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  norm_shift_ctrl_if.slave  bus
);

  localparam int SV_MAX = max_shift(EW);

  // ---------------- handshake ----------------
  logic accept_en_q;
  logic s1_adv_s;
  logic s2_adv_s;

  // ---------------- stage 1 ----------------
  logic           s1_valid_q;
  logic [SWR-1:0] s1_data_q;
  logic [EWE-1:0] s1_exp_q;
  logic [EW-1:0]  s1_pos_q;
  logic           s1_zero_q;
  logic [EW-1:0]  lzd_pos_s;
  logic           lzd_zero_s;

  // ---------------- stage 2 ----------------
  logic           s2_valid_q;
  logic [SWR-1:0] data_q;
  logic           dir_q;
  logic [EW-1:0]  sv_q;
  logic [EWE-1:0] exp_q;
  logic           zero_q;
  logic           ovf_q;
  logic           unf_q;

  logic           dir_d;
  logic [EW-1:0]  sv_d;
  logic [EWE-1:0] exp_d;
  logic           zero_d;
  logic           ovf_d;
  logic           unf_d;
  norm_case_e     case_s;
  logic [EW:0]    lz_s;       // leading-zero count, one bit wide of EW
  logic [EWE:0]   exp_inc_s;  // Exp+1 carried one bit wider so it never wraps
  logic [EWE-1:0] exp_m1_s;

`ifdef NORM_STICKY_EN
  logic sticky_q;
  logic sticky_d;
`endif

  // S2 may take a new beat when empty or when downstream drains it
  assign s2_adv_s   = !s2_valid_q || bus.ready_i;
  // S1 may take a new beat when empty or when it can move into S2
  assign s1_adv_s   = !s1_valid_q || s2_adv_s;
  assign bus.ready_o = accept_en_q && s1_adv_s;

  lzd_priority_enc #(
    .SWR (SWR),
    .EW  (EW)
  ) u_lzd (
    .data_i (bus.Data_i),
    .pos_o  (lzd_pos_s),
    .zero_o (lzd_zero_s)
  );

  // Hold ready_o low until the first clock edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept_en_q <= 1'b0;
    end else begin
      accept_en_q <= 1'b1;
    end
  end

  // Stage 1: capture the incoming beat and its leading-one position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= {SWR{1'b0}};
      s1_exp_q   <= {EWE{1'b0}};
      s1_pos_q   <= {EW{1'b0}};
      s1_zero_q  <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_q <= bus.valid_i && accept_en_q;
      if (bus.valid_i) begin
        s1_data_q <= bus.Data_i;
        s1_exp_q  <= bus.Exp_i;
        s1_pos_q  <= lzd_pos_s;
        s1_zero_q <= lzd_zero_s;
      end
    end
  end

  assign lz_s      = (EW+1)'(SWR - 2) - (EW+1)'(s1_pos_q);
  assign exp_inc_s = (EWE+1)'(s1_exp_q) + (EWE+1)'(1);
  assign exp_m1_s  = s1_exp_q - EWE'(1);

  // Classify the S1 beat into exactly one result class (flags mutually exclusive)
  always_comb begin
    case_s = CASE_ZERO;
    if (s1_zero_q) begin
      case_s = CASE_ZERO;
    end else if (s1_data_q[SWR-1]) begin
      case_s = CASE_CARRY;
    end else if ((EWE+1)'(s1_exp_q) > (EWE+1)'(lz_s)) begin
      case_s = CASE_NORM;
    end else begin
      case_s = CASE_UNF;
    end
  end

  // Build shift control, adjusted exponent and flags for the classified beat
  always_comb begin
    dir_d  = SHIFT_LEFT;
    sv_d   = {EW{1'b0}};
    exp_d  = {EWE{1'b0}};
    zero_d = 1'b0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
`ifdef NORM_STICKY_EN
    sticky_d = 1'b0;
`endif
    case (case_s)
      CASE_ZERO: begin
        zero_d = 1'b1;
      end
      CASE_CARRY: begin
        dir_d = SHIFT_RIGHT;
        sv_d  = EW'(1);
`ifdef NORM_STICKY_EN
        sticky_d = s1_data_q[0];
`endif
        if (exp_inc_s >= (EWE+1)'({EWE{1'b1}})) begin
          ovf_d = 1'b1;
          exp_d = {EWE{1'b1}};
        end else begin
          exp_d = exp_inc_s[EWE-1:0];
        end
      end
      CASE_NORM: begin
        exp_d = s1_exp_q - EWE'(lz_s);
        if (lz_s > (EW+1)'(SV_MAX)) begin
          sv_d = EW'(SV_MAX);
        end else begin
          sv_d = lz_s[EW-1:0];
        end
      end
      CASE_UNF: begin
        // Shift only as far as the exponent allows; result becomes denormal
        unf_d = 1'b1;
        if (s1_exp_q == {EWE{1'b0}}) begin
          sv_d = {EW{1'b0}};
        end else if ((EWE+1)'(exp_m1_s) > (EWE+1)'(SV_MAX)) begin
          sv_d = EW'(SV_MAX);
        end else begin
          sv_d = EW'(exp_m1_s);
        end
      end
      default: begin
        dir_d = SHIFT_LEFT;
      end
    endcase
  end

  // Stage 2: register outputs; hold everything while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      data_q     <= {SWR{1'b0}};
      dir_q      <= 1'b0;
      sv_q       <= {EW{1'b0}};
      exp_q      <= {EWE{1'b0}};
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
`ifdef NORM_STICKY_EN
      sticky_q   <= 1'b0;
`endif
    end else if (s2_adv_s) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        data_q   <= s1_data_q;
        dir_q    <= dir_d;
        sv_q     <= sv_d;
        exp_q    <= exp_d;
        zero_q   <= zero_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
`ifdef NORM_STICKY_EN
        sticky_q <= sticky_d;
`endif
      end
    end
  end

  assign bus.valid_o          = s2_valid_q;
  assign bus.Data_o           = data_q;
  assign bus.FSM_left_right_o = dir_q;
  assign bus.Shift_Value_o    = sv_q;
  assign bus.bit_shift_o      = 1'b0;
  assign bus.Exp_o            = exp_q;
  assign bus.zero_o           = zero_q;
  assign bus.ovf_o            = ovf_q;
  assign bus.unf_o            = unf_q;
`ifdef NORM_STICKY_EN
  assign bus.sticky_o         = sticky_q;
`endif

endmodule
